// File: rtl/id_ex_pkg.sv
// id_ex_pkg: control-bundle layout, ALUOp encodings and shared widths for the ID/EX stage
package id_ex_pkg;
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;
  localparam int REG_AW        = 5;
  localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b11
  } aluop_e;
endpackage

// File: rtl/id_ex_hazard_detect.sv
// id_ex_hazard_detect: load-use detection between the load in EX and the instruction in ID
module id_ex_hazard_detect
  import id_ex_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_addr_i,
  input  logic              id_valid_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_stall_o
);
  logic load_use;
  assign load_use = ex_valid_i & ex_memread_i & (ex_rt_addr_i != '0) & id_valid_i &
                    ((use_rs_i & (ex_rt_addr_i == rs_addr_i)) | (use_rt_i & (ex_rt_addr_i == rt_addr_i)));
  assign hazard_stall_o = load_use & ~flush_i & ~stall_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with flush/load-use bubbles, global hold and a saturating bubble counter
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              id_valid_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_pc_plus4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_addr_o,
  output logic [REG_AW-1:0] ex_rt_addr_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  localparam int REC_W = CTRL_W + 1 + 4 * DATA_W + 3 * REG_AW;
  logic [REC_W-1:0] rec_q, rec_d, rec_load;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble, bump;
  id_ex_hazard_detect u_hazard (
    .ex_valid_i    (ex_valid_o),
    .ex_memread_i  (ex_ctrl_o[CTRL_MEMREAD]),
    .ex_rt_addr_i  (ex_rt_addr_o),
    .id_valid_i    (id_valid_i),
    .use_rs_i      (use_rs_i),
    .use_rt_i      (use_rt_i),
    .rs_addr_i     (rs_addr_i),
    .rt_addr_i     (rt_addr_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .hazard_stall_o(hazard_stall_o)
  );
  assign rec_load = {id_valid_i ? ctrl_i : CTRL_NOP, id_valid_i, pc_plus4_i, rs_data_i,
                     rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i};
  // A bubble is all-zero, so it can never carry RegWrite or MemWrite
  assign bubble = flush_i | hazard_stall_o;
  assign bump   = (flush_i & (ex_valid_o | id_valid_i)) | hazard_stall_o;
  always_comb begin
    rec_d = bubble ? '0 : stall_i ? rec_q : rec_load;
    cnt_d = (bump && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rec_q <= '0;
      cnt_q <= '0;
    end else begin
      rec_q <= rec_d;
      cnt_q <= cnt_d;
    end
  end
  assign {ex_ctrl_o, ex_valid_o, ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
          ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o} = rec_q;
  assign bubble_cnt_o = cnt_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. Sits directly downstream of the main decoder.
- Captures the decoder's 8-bit EX/MEM/WB control bundle with the decoded operands and register addresses, and presents them to the EX stage.
- Inserts bubbles on flush and on load-use hazards, and holds on global stall.
- Contains the load-use hazard detector, which drives the PC / IF-ID hold signal, plus a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 32, datapath width (operands, PC+4, immediate)
CNT_W, 16, width of the bubble counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_n_i  in  1  asynchronous active-low reset
ctrl_i  in  8  decoder bundle {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst}; bit7=RegWrite … bit0=RegDst
id_valid_i  in  1  ID holds a real instruction
use_rs_i  in  1  ID instruction reads rs
use_rt_i  in  1  ID instruction reads rt
pc_plus4_i  in  DATA_W  PC+4 of the ID instruction
rs_data_i  in  DATA_W  register file read port A
rt_data_i  in  DATA_W  register file read port B
imm_i  in  DATA_W  sign-extended immediate
rs_addr_i  in  5  instr[25:21]
rt_addr_i  in  5  instr[20:16]
rd_addr_i  in  5  instr[15:11]
stall_i  in  1  global hold (e.g. memory wait)
flush_i  in  1  kill ID/EX contents (taken branch/jump resolved downstream)
ex_ctrl_o  out  8  registered control bundle, same bit order
ex_valid_o  out  1  registered valid
ex_pc_plus4_o  out  DATA_W  registered PC+4
ex_rs_data_o  out  DATA_W  registered operand A
ex_rt_data_o  out  DATA_W  registered operand B
ex_imm_o  out  DATA_W  registered immediate
ex_rs_addr_o  out  5  registered rs (for forwarding unit)
ex_rt_addr_o  out  5  registered rt
ex_rd_addr_o  out  5  registered rd
hazard_stall_o  out  1  combinational: hold PC and IF/ID this cycle
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, rst_n_i=0): every registered output is cleared to 0 (ctrl, valid, data, addresses, bubble_cnt). hazard_stall_o=0 while in reset. Reset mid-operation discards the held instruction immediately, without waiting for a clock edge.
- Latency: 1 cycle. An ID value loaded at edge N appears on ex_* after edge N.
- load_use = ex_valid_o & ex_ctrl_o[5] & (ex_rt_addr_o!=0) & id_valid_i & ((use_rs_i & ex_rt_addr_o==rs_addr_i) | (use_rt_i & ex_rt_addr_o==rt_addr_i)).
- hazard_stall_o = load_use & ~flush_i & ~stall_i.
- Per-edge update, in priority order:
  1. flush_i=1: bubble. ex_ctrl_o=0, ex_valid_o=0, all data/address fields=0. flush_i also overrides stall_i.
  2. stall_i=1: hold all registers unchanged. No hazard bubble is inserted.
  3. load_use=1: bubble (as in 1). The ID instruction stays in IF/ID, held externally by hazard_stall_o, and reloads on the next edge.
  4. Otherwise: load. ex_ctrl_o = id_valid_i ? ctrl_i : 0, ex_valid_o=id_valid_i, and all fields load from their inputs.
- A bubble must never carry RegWrite or MemWrite=1, so there are no architectural side effects.
- Jump opcodes present undefined controls on ctrl_i; id_valid_i=0 for them is not required, but the register captures ctrl_i bit-exact.
- A load-use bubble lasts exactly one cycle. The next cycle ex_ctrl_o[5]=0, so load_use deasserts and the instruction proceeds.
- bubble_cnt_o: +1 on each edge taking path 1 or 3 with a valid instruction discarded or postponed (path 1 counts only if ex_valid_o or id_valid_i was 1; path 3 always counts). Saturates at all-ones. It does not increment under stall_i unless flush_i is set.
- Register address 0 never causes a hazard.

Decomposition:
- Shared package: control-bundle bit indices (CTRL_REGWRITE=7 … CTRL_REGDST=0, CTRL_W=8), the ALUOp encodings (00 add, 01 sub/compare, 11 R-type funct), and the NOP bundle constant 8'h00.
- One sub-module: id_ex_hazard_detect (pure combinational load_use / hazard_stall_o). Registers and counter stay in id_ex_stage.

Test Plan:
- Reset: drive ctrl_i=8'hFF, rst_n_i=0 mid-cycle -> all ex_* = 0 immediately, bubble_cnt_o=0, hazard_stall_o=0.
- Pass-through: addi (ctrl_i=8'b10001000, rs=3, rt=4, imm=0x10), id_valid_i=1 -> next cycle ex_ctrl_o=8'h88, ex_rt_addr_o=4, ex_imm_o=0x10.
- Load-use: lw $5 (ctrl 8'b11101000) followed by R-type reading rs=5, use_rs_i=1 -> hazard_stall_o=1 for exactly one cycle; ex_ctrl_o=0 on the next cycle; the R-type then arrives with ctrl 8'b10000111; bubble_cnt_o=1.
- Hazard on $0: lw $0 then add reading $0 -> hazard_stall_o stays 0, no bubble.
- stall_i=1 for 3 cycles with ID inputs changing -> ex_* unchanged throughout; a concurrent lw-hazard produces hazard_stall_o=0 and no bubble; normal load resumes after release.
- flush_i and stall_i both 1 with valid sw in ID -> ex_ctrl_o=0, ex_valid_o=0; bubble_cnt_o saturates at 0xFFFF after being preloaded near max by repeated flushes.
